// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data cache memory arbiter:
// line geometry and the arbiter state encoding.
package mem_pkg;

  // Line address width (word address bits [29:2]) and line width.
  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  // Arbiter states. The encoding is fixed so that debug probes and
  // waveform decoders elsewhere in the codebase keep working.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GNT_I   = 2'b01,
    ST_GNT_D   = 2'b10,
    ST_RELEASE = 2'b11
  } arb_state_e;

  // True while one of the caches owns the memory port.
  function automatic logic is_grant(input arb_state_e s);
    return (s == ST_GNT_I) || (s == ST_GNT_D);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and external memory line ports that meet
// at the arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the surrounding caches and memory.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int LINE_W = mem_pkg::LINE_W
) ();

  // I-cache side (read only)
  logic              ic_mem_read;
  logic [ADDR_W-1:0] ic_mem_addr;
  logic [LINE_W-1:0] ic_mem_rdata;
  logic              ic_mem_ready;

  // D-cache side (read miss or write-back)
  logic              dc_mem_read;
  logic              dc_mem_write;
  logic [ADDR_W-1:0] dc_mem_addr;
  logic [LINE_W-1:0] dc_mem_wdata;
  logic [LINE_W-1:0] dc_mem_rdata;
  logic              dc_mem_ready;

  // External memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  ic_mem_read, ic_mem_addr,
    output ic_mem_rdata, ic_mem_ready,
    input  dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata,
    output dc_mem_rdata, dc_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output ic_mem_read, ic_mem_addr,
    input  ic_mem_rdata, ic_mem_ready,
    output dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata,
    input  dc_mem_rdata, dc_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port between the
// I-cache and the D-cache. Grants are registered, completions are routed
// combinationally to the owner only, and each returned line is held in a
// per-port register that feeds the cache's rdata output.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int LINE_W = mem_pkg::LINE_W
) (
  input  logic          clk,
  input  logic          proc_reset,
  mem_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              d_write_q, d_write_d;
  logic [LINE_W-1:0] ic_line_q;
  logic [LINE_W-1:0] dc_line_q;

  logic              i_req;
  logic              d_req;
  logic              mem_read_c;
  logic              mem_write_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [LINE_W-1:0] mem_wdata_c;
  logic              ic_ready_c;
  logic              dc_ready_c;
  logic              grant_c;

  assign i_req   = bus.ic_mem_read;
  assign d_req   = bus.dc_mem_read | bus.dc_mem_write;
  assign grant_c = is_grant(state_q);

  // Next-state decision, round-robin bookkeeping and memory-side outputs.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    d_write_d   = d_write_q;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    ic_ready_c  = 1'b0;
    dc_ready_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // With both caches asking, the one not served last time wins.
        if (i_req && (!d_req || last_d_q)) begin
          state_d  = ST_GNT_I;
          last_d_d = 1'b0;
        end else if (d_req) begin
          state_d   = ST_GNT_D;
          last_d_d  = 1'b1;
          // Freeze the transaction type so a dropped request cannot
          // change the strobe halfway through a memory access.
          d_write_d = bus.dc_mem_write;
        end
      end

      ST_GNT_I: begin
        mem_read_c = 1'b1;
        mem_addr_c = bus.ic_mem_addr;
        if (bus.mem_ready) begin
          ic_ready_c = 1'b1;
          state_d    = ST_RELEASE;
        end
      end

      ST_GNT_D: begin
        mem_read_c  = ~d_write_q;
        mem_write_c = d_write_q;
        mem_addr_c  = bus.dc_mem_addr;
        mem_wdata_c = bus.dc_mem_wdata;
        if (bus.mem_ready) begin
          dc_ready_c = 1'b1;
          state_d    = ST_RELEASE;
        end
      end

      // One quiet cycle so the owner can drop its request before the
      // next arbitration decision.
      ST_RELEASE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Control state: FSM, round-robin flag and captured D transaction type.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q   <= ST_IDLE;
      last_d_q  <= 1'b0;
      d_write_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      d_write_q <= d_write_d;
    end
  end

  // Line capture: each port's register updates only on its own read completion.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      ic_line_q <= '0;
      dc_line_q <= '0;
    end else begin
      if (grant_c && ic_ready_c) begin
        ic_line_q <= bus.mem_rdata;
      end
      if (grant_c && dc_ready_c && !d_write_q) begin
        dc_line_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_read     = mem_read_c;
  assign bus.mem_write    = mem_write_c;
  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_wdata    = mem_wdata_c;
  assign bus.ic_mem_ready = ic_ready_c;
  assign bus.dc_mem_ready = dc_ready_c;
  assign bus.ic_mem_rdata = ic_line_q;
  assign bus.dc_mem_rdata = dc_line_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single 128-bit line-granular memory port between the read-only instruction cache and the read/write data cache. It sits between both caches' memory interfaces and the external memory. It serializes their miss and write-back transactions with round-robin fairness, routes `mem_ready` to the owner only, and holds the returned line for the owner's buffer cycle.

## Interface
Parameters:
- `ADDR_W`, default 28: line address width (word address bits [29:2]).
- `LINE_W`, default 128: line width.

Ports:
- `clk`  in  1: clock.
- `proc_reset`  in  1: reset, asynchronous, active-high.
- `ic_mem_read`  in  1: I-cache line read request, level, held until `ic_mem_ready`.
- `ic_mem_addr`  in  ADDR_W: I-cache line address.
- `ic_mem_rdata`  out  LINE_W: latched line for the I-cache.
- `ic_mem_ready`  out  1: one-cycle completion to the I-cache.
- `dc_mem_read`  in  1: D-cache read request, level.
- `dc_mem_write`  in  1: D-cache write-back request, level. Mutually exclusive with `dc_mem_read`.
- `dc_mem_addr`  in  ADDR_W: D-cache line address.
- `dc_mem_wdata`  in  LINE_W: D-cache write-back line.
- `dc_mem_rdata`  out  LINE_W: latched line for the D-cache.
- `dc_mem_ready`  out  1: one-cycle completion to the D-cache.
- `mem_read`  out  1: memory read strobe, level.
- `mem_write`  out  1: memory write strobe, level.
- `mem_addr`  out  ADDR_W: memory line address.
- `mem_wdata`  out  LINE_W: memory write line.
- `mem_rdata`  in  LINE_W: memory read line, valid in the `mem_ready` cycle.
- `mem_ready`  in  1: memory completion pulse.

## Operation
- FSM states: IDLE, GNT_I, GNT_D, RELEASE. Round-robin flag `last_d` is 1 when the D-cache was granted last.
- IDLE:
  - Only I requesting -> GNT_I.
  - Only D requesting (read or write) -> GNT_D.
  - Both requesting -> GNT_I if `last_d`=1, otherwise GNT_D.
  - `last_d` updates on entry to a grant state.
- GNT_I:
  - `mem_read`=1, `mem_addr`=`ic_mem_addr`.
  - On `mem_ready`: `ic_mem_ready`=1 in the same cycle, `mem_rdata` is captured into the I line register, next state is RELEASE.
- GNT_D:
  - `mem_read`=`dc_mem_read`, `mem_write`=`dc_mem_write`, `mem_addr`/`mem_wdata` come from the D-cache.
  - The read/write type is captured on grant entry and stays fixed for the transaction.
  - On `mem_ready`: `dc_mem_ready`=1. A read captures the D line register; a write leaves it unchanged. Next state is RELEASE.
- RELEASE: all memory strobes 0. Lasts one cycle, which lets the owner drop its request, then goes to IDLE.
- Write-back then allocate from the D-cache: two separate D transactions. A waiting I request wins the second arbitration because `last_d`=1.
- Request dropped mid-grant (protocol violation): strobes stay asserted until `mem_ready` so the memory transaction completes. That completion is still forwarded to the owner. No abort.
- Line registers hold their value until the next capture for that port. `ic_mem_rdata`/`dc_mem_rdata` are driven directly from these registers.
- Outside the grant states, `mem_addr`/`mem_wdata` are 0.

## Timing
- Reset values:
  - State IDLE, `last_d`=0.
  - Both line registers 0.
  - `mem_read`, `mem_write`, `ic_mem_ready`, `dc_mem_ready` all 0; `mem_addr`/`mem_wdata` 0.
- Reset mid-transaction drops all strobes immediately. The memory is reset by the same signal.
- Latency:
  - Request seen in IDLE at cycle N -> memory strobe at N+1 (registered grant).
  - Ready at cycle M -> latched line valid at M+1 (owner's buffer cycle) -> IDLE at M+2.
- Minimum spacing between memory transactions: 2 idle-strobe cycles (RELEASE plus the IDLE decision).
- `ic_mem_ready`/`dc_mem_ready` are combinational from `mem_ready` AND the grant state. Both are never 1 in the same cycle.
- `mem_ready` outside GNT_I/GNT_D is ignored.

## Structure
- Shared package `mem_pkg`: state encoding (2-bit: IDLE=00, GNT_I=01, GNT_D=10, RELEASE=11), `ADDR_W`, `LINE_W`.
- No sub-module. The line capture registers stay inline.

## Test plan
- I-only read of addr 0x0000010, memory ready after 3 cycles with line 0x...DEADBEEF -> `mem_read` from N+1, `ic_mem_ready` pulse with ready, `ic_mem_rdata`=0x...DEADBEEF the next cycle, `dc_mem_ready` stays 0.
- I and D read requested in the same cycle after reset (`last_d`=0) -> D served first, then I. `mem_addr` switches only after RELEASE.
- D write-back to 0x0000020 with wdata 0xA5..A5 -> `mem_write`=1, `mem_wdata`=0xA5..A5. `dc_mem_rdata` unchanged after ready.
- Continuous requests from both ports for 6 transactions -> grants strictly alternate D,I,D,I,D,I.
- `proc_reset` pulsed during GNT_D -> strobes 0 the same cycle, state IDLE. The next request is granted normally.
- Spurious `mem_ready` in IDLE -> no ready forwarded and line registers unchanged.
